multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle RV32I controller.
- FSM sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a ready handshake.
- Drives enables and mux selects of the multi-cycle datapath: PC, IR, OldPC and ALUOut registers, and one result bus.
- Counts retired instructions and flags memory wait timeouts.

Parameters:
RET_CNT_W, 32, width of retired-instruction counter (wraps at 2^RET_CNT_W)
MEM_WAIT_MAX, 0, max cycles waiting on mem_ready before bus_err; 0 = wait forever

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
op  in  7  IR[6:0]
f3  in  3  IR[14:12]
f7  in  7  IR[31:25]
zero  in  1  ALU result == 0
sign_bit  in  1  ALU result MSB
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req
adr_sel  out  1  0 = PC, 1 = ALUOut
ir_we  out  1  load IR
old_pc_we  out  1  load OldPC
pc_we  out  1  load PC
pc_src  out  2  00 = ALU direct, 01 = ALUOut
reg_we  out  1  register file write
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RS1, 11 = zero
alu_src_b  out  2  00 = RS2, 01 = Imm, 10 = constant 4
alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 111 invalid
imm_sel  out  3  000 I, 001 S, 010 B, 011 J, 100 U
result_sel  out  2  00 = ALUOut, 01 = mem data, 10 = ALU direct, 11 = PC
instret  out  RET_CNT_W  retired-instruction count
bus_err  out  1  sticky memory-timeout flag

Behaviour:
- Outputs are combinational from state, op, f3, f7, zero, sign_bit and mem_ready (Mealy on mem_ready only).
- Outputs not listed for a state are 0.
- Reset: state = FETCH, instret = 0, bus_err = 0, wait counter = 0. Reset takes effect immediately even mid-transaction, so mem_req drops asynchronously.

States:
- FETCH: mem_req=1, adr_sel=0. When mem_ready=1: ir_we=1, old_pc_we=1, pc_we=1, alu_src_a=00, alu_src_b=10, ADD, pc_src=00; go to DECODE. Otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, ADD (branch/JAL target into ALUOut), imm_sel by op.
  - Next state: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; other -> ILLEGAL handling.
- MEM_ADDR: alu_src_a=10, alu_src_b=01, ADD, imm_sel I (load) or S (store). Go to MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_req=1, adr_sel=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_we=1, result_sel=01. Go to FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, adr_sel=1. On mem_ready go to FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00.
  - alu_op from {f7,f3}: 0000000/000 ADD, 0100000/000 SUB, 0000000/111 AND, 0000000/110 OR, 0000000/010 SLT; else 111.
  - Go to ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=01, imm_sel I. alu_op from f3 only (000 ADD, 111 AND, 110 OR, 010 SLT). Go to ALU_WB.
- ALU_WB: reg_we=1, result_sel=00. Go to FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, SUB.
  - Taken: f3 = 000 and zero; 001 and !zero; 100 and sign_bit; 101 and !sign_bit.
  - If taken: pc_we=1, pc_src=01. Go to FETCH.
  - Any other f3 is not taken.
- JAL: pc_we=1, pc_src=01, reg_we=1, result_sel=11 (PC already equals OldPC+4). Go to FETCH.
- JALR: alu_src_a=10, alu_src_b=01, imm_sel I, ADD; pc_we=1, pc_src=00 (datapath clears bit 0); reg_we=1, result_sel=11. Go to FETCH. The register file samples the old PC at the same edge.
- LUI: alu_src_a=11, alu_src_b=01, imm_sel U, ADD, reg_we=1, result_sel=10. Go to FETCH.

Counters and errors:
- instret increments by 1 on every transition into FETCH from a non-FETCH state, wrapping to 0.
- Wait counter: increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on leaving the state.
- If MEM_WAIT_MAX > 0 and the wait counter reaches MEM_WAIT_MAX: bus_err=1 (sticky until reset), state -> FETCH, instret unchanged.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
Macro MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP. TRAP asserts output illegal=1 (extra 1-bit port) with all enables 0, and holds until reset.
  - alu_op=111 from EXEC_R also goes to TRAP instead of ALU_WB.
- Undefined:
  - Unknown opcode -> FETCH as a NOP, counted in instret.
  - alu_op=111 proceeds to ALU_WB with no trap.
  - No illegal port.

Test Plan:
- add x3,x1,x2 with mem_ready after 2 wait cycles in fetch -> FETCH held 3 cycles, then DECODE, EXEC_R (alu_op=000), ALU_WB (reg_we=1, result_sel=00); instret 0->1.
- lw with mem_ready=1 immediately -> FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB: 5 cycles, result_sel=01 in MEM_WB; sw -> mem_we=1 in MEM_WRITE, no reg_we.
- beq with zero=1 -> pc_we=1, pc_src=01 in BRANCH; bne with zero=1 -> pc_we=0; bge with sign_bit=0 -> taken.
- jal then jalr -> reg_we=1 and result_sel=11 in both; pc_src=01 for jal, 00 for jalr.
- MEM_WAIT_MAX=4, mem_ready tied to 0 -> bus_err=1 on the 4th wait cycle, state returns to FETCH, instret unchanged.
- rst driven low mid MEM_READ -> mem_req=0 immediately, instret=0; first cycle after release is FETCH. Also drive 2^RET_CNT_W retirements with RET_CNT_W=4 -> instret wraps 15->0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle FSM over a shared memory port, with retire counter and wait timeout.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on unknown opcodes or invalid R-type ops (adds the illegal output).
module multicycle_controller #(
    parameter int RET_CNT_W    = 32,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           f3,
    input  logic [6:0]           f7,
    input  logic                 zero,
    input  logic                 sign_bit,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_sel,
    output logic                 ir_we,
    output logic                 old_pc_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 reg_we,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_op,
    output logic [2:0]           imm_sel,
    output logic [1:0]           result_sel,
`ifdef MULTICYCLE_CTRL_TRAP_EN
    output logic                 illegal,
`endif
    output logic [RET_CNT_W-1:0] instret,
    output logic                 bus_err
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
                           S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
                           S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                           S_LUI = 4'd12, S_TRAP = 4'd13, S_OFF = 4'd15;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam logic [3:0] S_ILL = S_TRAP;
`else
    localparam logic [3:0] S_ILL = S_FETCH;
`endif
    logic [3:0]           r_state, w_next, w_state, w_dec_next, w_r_next;
    logic [31:0]          r_wait;
    logic [RET_CNT_W-1:0] r_instret;
    logic                 r_bus_err, w_wait, w_timeout, w_taken;
    logic [2:0]           w_i_alu, w_r_alu, w_imm_dec;

    // While reset is asserted the outputs decode from an idle encoding, so mem_req drops at once
    assign w_state   = rst ? r_state : S_OFF;
    assign w_i_alu   = f3 == 3'b000 ? 3'b000 : f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 :
                       f3 == 3'b010 ? 3'b100 : 3'b111;
    assign w_r_alu   = f7 == 7'b0000000 ? w_i_alu : (f7 == 7'b0100000 && f3 == 3'b000) ? 3'b001 : 3'b111;
    assign w_taken   = (f3 == 3'b000 && zero) || (f3 == 3'b001 && !zero) ||
                       (f3 == 3'b100 && sign_bit) || (f3 == 3'b101 && !sign_bit);
    assign w_imm_dec = op == OP_STORE ? 3'b001 : op == OP_BR ? 3'b010 : op == OP_JAL ? 3'b011 :
                       op == OP_LUI ? 3'b100 : 3'b000;
    assign w_dec_next = (op == OP_LOAD || op == OP_STORE) ? S_MEM_ADDR : op == OP_R ? S_EXEC_R :
                        op == OP_I ? S_EXEC_I : op == OP_BR ? S_BRANCH : op == OP_JAL ? S_JAL :
                        op == OP_JALR ? S_JALR : op == OP_LUI ? S_LUI : S_ILL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign w_r_next  = w_r_alu == 3'b111 ? S_TRAP : S_ALU_WB;
    assign illegal   = w_state == S_TRAP;
`else
    assign w_r_next  = S_ALU_WB;
`endif
    assign w_wait    = mem_req && !mem_ready;
    assign w_timeout = (MEM_WAIT_MAX > 0) && w_wait && r_wait == 32'(MEM_WAIT_MAX - 1);

    always_comb begin
        mem_req = 1'b0; mem_we = 1'b0; adr_sel = 1'b0; ir_we = 1'b0; old_pc_we = 1'b0; pc_we = 1'b0;
        pc_src = 2'b00; reg_we = 1'b0; alu_src_a = 2'b00; alu_src_b = 2'b00; alu_op = 3'b000;
        imm_sel = 3'b000; result_sel = 2'b00;
        case (w_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we = mem_ready; old_pc_we = mem_ready; pc_we = mem_ready;
                alu_src_b = mem_ready ? 2'b10 : 2'b00;
            end
            S_DECODE: begin alu_src_a = 2'b01; alu_src_b = 2'b01; imm_sel = w_imm_dec; end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10; alu_src_b = 2'b01;
                imm_sel = op == OP_STORE ? 3'b001 : 3'b000;
            end
            S_MEM_READ: begin mem_req = 1'b1; adr_sel = 1'b1; end
            S_MEM_WB: begin reg_we = 1'b1; result_sel = 2'b01; end
            S_MEM_WRITE: begin mem_req = 1'b1; mem_we = 1'b1; adr_sel = 1'b1; end
            S_EXEC_R: begin alu_src_a = 2'b10; alu_op = w_r_alu; end
            S_EXEC_I: begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = w_i_alu; end
            S_ALU_WB: reg_we = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10; alu_op = 3'b001;
                pc_we = w_taken; pc_src = w_taken ? 2'b01 : 2'b00;
            end
            S_JAL: begin pc_we = 1'b1; pc_src = 2'b01; reg_we = 1'b1; result_sel = 2'b11; end
            S_JALR: begin
                alu_src_a = 2'b10; alu_src_b = 2'b01;
                pc_we = 1'b1; reg_we = 1'b1; result_sel = 2'b11;
            end
            S_LUI: begin
                alu_src_a = 2'b11; alu_src_b = 2'b01; imm_sel = 3'b100;
                reg_we = 1'b1; result_sel = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    w_next = w_dec_next;
            S_MEM_ADDR:  w_next = op == OP_LOAD ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    w_next = w_r_next;
            S_EXEC_I:    w_next = S_ALU_WB;
            S_TRAP:      w_next = S_TRAP;
            default:     w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_FETCH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_wait && !w_timeout) ? r_wait + 32'd1 : '0;
            if (r_state != S_FETCH && w_next == S_FETCH && !w_timeout) r_instret <= r_instret + 1'b1;
            if (w_timeout) r_bus_err <= 1'b1;
        end
    end

    assign instret = r_instret;
    assign bus_err = r_bus_err;
endmodule
